// File: rtl/sarcon_pkg.sv
// Shared SAR controller types: FSM encoding, averaging clamp default and helper.
// Pure declarations; no timing or backpressure of its own.
package sarcon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_CONV   = 2'd2
    } state_t;

    localparam int AVG_MAX_DEF = 3;

    function automatic logic [2:0] clamp_avg(input logic [2:0] a, input int mx);
        return (int'(a) > mx) ? 3'(mx) : a;
    endfunction

endpackage

// File: rtl/sarcon_mc_if.sv
// Result handshake bundle: one buffered result with valid/ready.
// Data and channel hold while valid is high until the sink raises ready.
interface sarcon_mc_if #(
    parameter int N   = 12,
    parameter int CHW = 2
);
    logic           res_valid;
    logic           res_ready;
    logic [N-1:0]   res_data;
    logic [CHW-1:0] res_ch;

    modport master (output res_valid, output res_data, output res_ch, input res_ready);
    modport slave  (input res_valid, input res_data, input res_ch, output res_ready);
endinterface

// File: rtl/sarcon_core.sv
// Successive-approximation bit engine: one trial bit per cycle, MSB first.
// N cycles after the start edge; no backpressure, done marks the final bit cycle.
module sarcon_core #(
    parameter int N = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         comp,
    output logic [N-1:0] dq,
    output logic         done
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic          active;
    logic [N-1:0]  code;
    logic [IW-1:0] idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            code   <= '0;
            idx    <= '0;
        end else if (start) begin
            active <= 1'b1;
            code   <= {1'b1, {(N-1){1'b0}}};
            idx    <= IW'(N-1);
        end else if (active) begin
            code[idx] <= comp;
            if (idx == '0) begin
                active <= 1'b0;
            end else begin
                code[idx - 1'b1] <= 1'b1;
                idx              <= idx - 1'b1;
            end
        end
    end

    assign dq   = active ? code : '0;
    assign done = active && (idx == '0);
endmodule

// File: rtl/sarcon_mc.sv
// Multi-channel SAR scan controller with per-channel averaging and one-entry result buffer.
// Result valid the cycle after the last bit edge; a result arriving on a full, unpopped buffer is dropped with overrun.
module sarcon_mc
    import sarcon_pkg::*;
#(
    parameter int N       = 12,
    parameter int NCH     = 4,
    parameter int AVG_MAX = AVG_MAX_DEF,
    parameter int TSAMP   = 1,
    parameter int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            comp,
    input  logic            start,
    input  logic            cont,
    input  logic [NCH-1:0]  ch_mask,
    input  logic [2:0]      avg_log2,
    output logic            sample,
    output logic [N-1:0]    dq,
    output logic [CHW-1:0]  ch,
    output logic            busy,
    output logic            last_cycle,
    sarcon_mc_if.master     res,
    output logic            overrun
);
    localparam int AW = N + AVG_MAX;
    localparam int CW = (AVG_MAX > 0) ? AVG_MAX : 1;
    localparam int SW = (TSAMP > 1) ? $clog2(TSAMP) : 1;

    state_t         state, state_nx;
    logic [NCH-1:0] m_mask;
    logic           m_cont;
    logic [2:0]     m_avg;
    logic [SW-1:0]  scnt;
    logic [CW-1:0]  conv_cnt;
    logic [AW-1:0]  acc;
    logic           buf_vld;
    logic [N-1:0]   buf_dat;
    logic [CHW-1:0] buf_ch;

    logic           samp_end, core_done, slot_end, pop, wrap;
    logic [N-1:0]   core_dq, code;
    logic [AW-1:0]  acc_sum;
    logic [CW:0]    n_conv;
    logic [CHW-1:0] first_ch, lo_ch, nxt_ch;

    sarcon_core #(.N(N)) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .start (state == ST_SAMPLE && samp_end),
        .comp  (comp),
        .dq    (core_dq),
        .done  (core_done)
    );

    assign samp_end = (scnt == SW'(TSAMP - 1));
    assign code     = {core_dq[N-1:1], comp};
    assign acc_sum  = acc + AW'(code);
    assign n_conv   = (CW+1)'(1) << m_avg;
    assign slot_end = ({1'b0, conv_cnt} == n_conv - 1'b1);
    assign pop      = buf_vld && res.res_ready;

    // Downward scan: the last hit is the lowest qualifying channel.
    always_comb begin
        first_ch = '0;
        lo_ch    = '0;
        nxt_ch   = '0;
        wrap     = 1'b1;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (ch_mask[i]) first_ch = CHW'(i);
            if (m_mask[i])  lo_ch    = CHW'(i);
            if (m_mask[i] && i > int'(ch)) begin
                nxt_ch = CHW'(i);
                wrap   = 1'b0;
            end
        end
        if (wrap) nxt_ch = lo_ch;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (start && ch_mask != '0) state_nx = ST_SAMPLE;
            ST_SAMPLE: if (samp_end) state_nx = ST_CONV;
            ST_CONV:   if (core_done)
                           state_nx = (slot_end && wrap && !(m_cont && cont)) ? ST_IDLE : ST_SAMPLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mask   <= '0;
            m_cont   <= 1'b0;
            m_avg    <= '0;
            scnt     <= '0;
            conv_cnt <= '0;
            acc      <= '0;
            ch       <= '0;
            buf_vld  <= 1'b0;
            buf_dat  <= '0;
            buf_ch   <= '0;
            overrun  <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (pop) buf_vld <= 1'b0;
            case (state)
                ST_IDLE: if (start && ch_mask != '0) begin
                    m_mask   <= ch_mask;
                    m_cont   <= cont;
                    m_avg    <= clamp_avg(avg_log2, AVG_MAX);
                    ch       <= first_ch;
                    scnt     <= '0;
                    conv_cnt <= '0;
                    acc      <= '0;
                end
                ST_SAMPLE: scnt <= samp_end ? '0 : scnt + 1'b1;
                ST_CONV: if (core_done) begin
                    if (slot_end) begin
                        acc      <= '0;
                        conv_cnt <= '0;
                        ch       <= nxt_ch;
                        if (!buf_vld || pop) begin
                            buf_vld <= 1'b1;
                            buf_dat <= N'(acc_sum >> m_avg);
                            buf_ch  <= ch;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else begin
                        acc      <= acc_sum;
                        conv_cnt <= conv_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign res.res_valid = buf_vld;
    assign res.res_data  = buf_dat;
    assign res.res_ch    = buf_ch;
    assign sample        = (state == ST_SAMPLE);
    assign busy          = (state != ST_IDLE);
    assign last_cycle    = core_done;
    assign dq            = core_dq;
endmodule
